pcss_link_rx: RTL and testbench



---
 rtl/pcss_pkg.sv | 18 +
 rtl/pcss_sync_fifo.sv | 63 ++++++
 rtl/pcss_link_rx.sv | 109 ++++++++++
 tb/tb_pcss_link_rx.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcss_pkg.sv
// Shared constants for the PCSS chip-link receive path: link/stream widths,
// the end-of-run marker and the error-counter helper.
package pcss_pkg;

  localparam int CHIPDATA_WIDTH = 16;
  localparam int DATA_WIDTH     = 64;
  localparam int ERR_CNT_WIDTH  = 16;

  // The end-of-run word is all ones at any stream width; the fill bit lets
  // blocks with a non-default DATA_WIDTH build the matching marker.
  localparam logic                  END_MARKER_FILL = 1'b1;
  localparam logic [DATA_WIDTH-1:0] END_MARKER      = {DATA_WIDTH{END_MARKER_FILL}};

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    return (v == {ERR_CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pcss_sync_fifo.sv
// Small synchronous FIFO with a combinational head read; reports the
// occupancy it will have after the current edge so callers can register flow control.
module pcss_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [CNW-1:0]   count_next
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNW-1:0]   count_q, count_d;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CNW'(push) - CNW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data    = mem_q[rd_ptr_q];
  assign rd_valid   = (count_q != '0);
  assign count_next = count_d;

endmodule

// File: rtl/pcss_link_rx.sv
// Chip-link receiver: parity-checks incoming flits, packs NF flits MSB-first
// into one stream word and buffers words for an AXI-stream master port.
module pcss_link_rx #(
  parameter int CHIPDATA_WIDTH = pcss_pkg::CHIPDATA_WIDTH,
  parameter int DATA_WIDTH     = pcss_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH     = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHIPDATA_WIDTH-1:0] link_data_in,
  input  logic                      link_valid,
  input  logic                      link_par,
  output logic                      link_ready,
  output logic                      link_err,
  output logic [DATA_WIDTH-1:0]     M_AXIS_tdata,
  output logic                      M_AXIS_tvalid,
  output logic                      M_AXIS_tlast,
  output logic [DATA_WIDTH/8-1:0]   M_AXIS_tkeep,
  input  logic                      M_AXIS_tready,
  output logic [15:0]               err_cnt
);
  import pcss_pkg::*;

  localparam int NF     = DATA_WIDTH / CHIPDATA_WIDTH;
  localparam int FCW    = (NF > 1) ? $clog2(NF) : 1;
  localparam int PART_W = DATA_WIDTH - CHIPDATA_WIDTH;
  localparam int FIFO_CNW = $clog2(FIFO_DEPTH + 1);
  localparam logic [DATA_WIDTH-1:0] EOR_WORD = {DATA_WIDTH{END_MARKER_FILL}};

  logic [FCW-1:0]    fcnt_q, fcnt_d;
  logic [PART_W-1:0] part_q, part_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic              link_err_q, link_err_d;
  logic              ready_q, ready_d;

  logic                  xfer, par_ok, good_flit, bad_flit, last_flit;
  logic [DATA_WIDTH-1:0] assembled;
  logic                  push, pop, fifo_valid;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic [FIFO_CNW-1:0]   fifo_count_next;

  // Even parity across the flit plus its parity bit.
  assign par_ok    = (link_par == ^link_data_in);
  assign xfer      = link_valid && ready_q;
  assign good_flit = xfer && par_ok;
  assign bad_flit  = xfer && !par_ok;
  assign last_flit = (fcnt_q == FCW'(NF - 1));
  assign assembled = {part_q, link_data_in};

  assign push = good_flit && last_flit;
  assign pop  = fifo_valid && M_AXIS_tready;

  always_comb begin
    fcnt_d     = fcnt_q;
    part_d     = part_q;
    err_cnt_d  = err_cnt_q;
    link_err_d = bad_flit;
    // Flow control is registered from the post-edge occupancy, so it is low
    // exactly while the buffer is full and no flit can be taken into a full FIFO.
    ready_d    = (fifo_count_next != FIFO_CNW'(FIFO_DEPTH));
    if (bad_flit) begin
      fcnt_d    = '0;
      part_d    = '0;
      err_cnt_d = sat_inc(err_cnt_q);
    end else if (good_flit) begin
      part_d = assembled[PART_W-1:0];
      fcnt_d = last_flit ? '0 : fcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q     <= '0;
      part_q     <= '0;
      err_cnt_q  <= '0;
      link_err_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      fcnt_q     <= fcnt_d;
      part_q     <= part_d;
      err_cnt_q  <= err_cnt_d;
      link_err_q <= link_err_d;
      ready_q    <= ready_d;
    end
  end

  pcss_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (assembled),
    .pop        (pop),
    .rd_data    (fifo_data),
    .rd_valid   (fifo_valid),
    .count_next (fifo_count_next)
  );

  assign link_ready    = ready_q;
  assign link_err      = link_err_q;
  assign err_cnt       = err_cnt_q;
  assign M_AXIS_tvalid = fifo_valid;
  assign M_AXIS_tdata  = fifo_data;
  assign M_AXIS_tlast  = fifo_valid && (fifo_data == EOR_WORD);
  assign M_AXIS_tkeep  = '1;

endmodule

// File: tb/tb_pcss_link_rx.sv
// Bench for pcss_link_rx: scenario tasks drive flits, a reference packer
// queues expected words and a negedge monitor checks them as they leave.
module tb_pcss_link_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] link_data_in;
  logic        link_valid;
  logic        link_par;
  logic        link_ready;
  logic        link_err;
  logic [63:0] M_AXIS_tdata;
  logic        M_AXIS_tvalid;
  logic        M_AXIS_tlast;
  logic [7:0]  M_AXIS_tkeep;
  logic        M_AXIS_tready;
  logic [15:0] err_cnt;

  int tests_run = 0;
  int fail_cnt  = 0;

  // {tlast, tdata}
  logic [64:0] exp_q[$];
  logic [64:0] exp_w;
  int          m_idx = 0;
  logic [63:0] m_part = '0;
  logic [15:0] exp_err = '0;

  always #5 clk = ~clk;

  pcss_link_rx dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .link_data_in  (link_data_in),
    .link_valid    (link_valid),
    .link_par      (link_par),
    .link_ready    (link_ready),
    .link_err      (link_err),
    .M_AXIS_tdata  (M_AXIS_tdata),
    .M_AXIS_tvalid (M_AXIS_tvalid),
    .M_AXIS_tlast  (M_AXIS_tlast),
    .M_AXIS_tkeep  (M_AXIS_tkeep),
    .M_AXIS_tready (M_AXIS_tready),
    .err_cnt       (err_cnt)
  );

  // Handshake: a flit moves on a rising edge with link_valid && link_ready;
  // a word moves on a rising edge with M_AXIS_tvalid && M_AXIS_tready.
  always @(negedge clk) begin
    if (rst_n && M_AXIS_tvalid) begin
      tests_run++;
      if (M_AXIS_tkeep !== 8'hFF) begin
        fail_cnt++;
        $display("FAIL tkeep: got %h expected ff", M_AXIS_tkeep);
      end
      if (M_AXIS_tready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          fail_cnt++;
          $display("FAIL unexpected_word: got %h with no word expected", M_AXIS_tdata);
        end else begin
          exp_w = exp_q.pop_front();
          if ({M_AXIS_tlast, M_AXIS_tdata} !== exp_w) begin
            fail_cnt++;
            $display("FAIL word_out: got last=%b data=%h expected last=%b data=%h",
                     M_AXIS_tlast, M_AXIS_tdata, exp_w[64], exp_w[63:0]);
          end
        end
      end
    end
  end

  task automatic model_reset();
    exp_q.delete();
    m_idx   = 0;
    m_part  = '0;
    exp_err = '0;
  endtask

  // Drives one flit and returns 1 time unit after the edge that accepted it.
  task automatic send_flit(input logic [15:0] d, input bit bad);
    int waited = 0;
    link_data_in = d;
    link_par     = (^d) ^ bad;
    link_valid   = 1'b1;
    forever begin
      @(negedge clk);
      if (link_ready) break;
      waited++;
      if (waited > 200) begin
        tests_run++;
        fail_cnt++;
        $display("FAIL flit_accept_timeout: link_ready=%b after %0d cycles, expected 1", link_ready, waited);
        break;
      end
    end
    @(posedge clk);
    #1;
    link_valid = 1'b0;
    if (bad) begin
      m_idx   = 0;
      m_part  = '0;
      exp_err = (exp_err == 16'hFFFF) ? exp_err : exp_err + 16'd1;
      tests_run++;
      if (link_err !== 1'b1) begin
        fail_cnt++;
        $display("FAIL link_err_pulse: got %b expected 1", link_err);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (link_err !== 1'b0) begin
        fail_cnt++;
        $display("FAIL link_err_width: got %b expected 0", link_err);
      end
      tests_run++;
      if (err_cnt !== exp_err) begin
        fail_cnt++;
        $display("FAIL err_cnt_step: got %h expected %h", err_cnt, exp_err);
      end
    end else begin
      m_part = {m_part[47:0], d};
      m_idx++;
      if (m_idx == 4) begin
        exp_q.push_back({(m_part == 64'hFFFF_FFFF_FFFF_FFFF), m_part});
        m_idx  = 0;
        m_part = '0;
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || M_AXIS_tvalid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL drain: %0d words still expected, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    link_valid    = 1'b0;
    link_data_in  = '0;
    link_par      = 1'b0;
    M_AXIS_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({link_ready, link_err, M_AXIS_tvalid, M_AXIS_tlast} !== 4'b0000) begin
      fail_cnt++;
      $display("FAIL reset_ctrl: ready/err/tvalid/tlast=%b expected 0000",
               {link_ready, link_err, M_AXIS_tvalid, M_AXIS_tlast});
    end
    tests_run++;
    if (M_AXIS_tdata !== 64'h0 || err_cnt !== 16'h0) begin
      fail_cnt++;
      $display("FAIL reset_data: tdata=%h err_cnt=%h expected 0 and 0", M_AXIS_tdata, err_cnt);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (link_ready !== 1'b1) begin
      fail_cnt++;
      $display("FAIL ready_after_reset: got %b expected 1", link_ready);
    end
  endtask

  task automatic test_basic();
    send_flit(16'h1234, 0);
    send_flit(16'h5678, 0);
    send_flit(16'h9ABC, 0);
    tests_run++;
    if (M_AXIS_tvalid !== 1'b0) begin
      fail_cnt++;
      $display("FAIL early_tvalid: got %b expected 0", M_AXIS_tvalid);
    end
    send_flit(16'hDEF0, 0);
    tests_run++;
    if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 64'h1234_5678_9ABC_DEF0) begin
      fail_cnt++;
      $display("FAIL basic_word: tvalid=%b tdata=%h expected 1 123456789abcdef0", M_AXIS_tvalid, M_AXIS_tdata);
    end
    tests_run++;
    if (M_AXIS_tlast !== 1'b0 || M_AXIS_tkeep !== 8'hFF) begin
      fail_cnt++;
      $display("FAIL basic_side: tlast=%b tkeep=%h expected 0 ff", M_AXIS_tlast, M_AXIS_tkeep);
    end
    wait_drain();
  endtask

  task automatic test_end_marker();
    for (int i = 0; i < 4; i++) send_flit(16'hFFFF, 0);
    tests_run++;
    if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tlast !== 1'b1 || M_AXIS_tdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      fail_cnt++;
      $display("FAIL end_marker: tvalid=%b tlast=%b tdata=%h expected 1 1 all-ones",
               M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tdata);
    end
    wait_drain();
  endtask

  task automatic test_parity_err();
    send_flit(16'h1111, 0);
    send_flit(16'h2222, 1);
    tests_run++;
    if (err_cnt !== 16'd1) begin
      fail_cnt++;
      $display("FAIL parity_err_cnt: got %h expected 0001", err_cnt);
    end
    send_flit(16'h3333, 0);
    send_flit(16'h4444, 0);
    send_flit(16'h5555, 0);
    send_flit(16'h6666, 0);
    tests_run++;
    if (M_AXIS_tdata !== 64'h3333_4444_5555_6666) begin
      fail_cnt++;
      $display("FAIL word_after_err: got %h expected 3333444455556666", M_AXIS_tdata);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    M_AXIS_tready = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) send_flit(16'(16'hA000 + $urandom_range(0, 16'h0FFF)), 0);
      end
      begin
        int n = 0;
        logic [63:0] hold;
        bit stable = 1;
        @(negedge clk);
        while (link_ready && n < 400) begin
          @(negedge clk);
          n++;
        end
        tests_run++;
        if (link_ready !== 1'b0 || exp_q.size() != 2) begin
          fail_cnt++;
          $display("FAIL ready_fall: ready=%b words_buffered=%0d expected 0 and 2", link_ready, exp_q.size());
        end
        hold = M_AXIS_tdata;
        repeat (6) begin
          @(negedge clk);
          if (M_AXIS_tdata !== hold || link_ready !== 1'b0 || M_AXIS_tvalid !== 1'b1) stable = 0;
        end
        tests_run++;
        if (!stable || exp_q.size() != 2) begin
          fail_cnt++;
          $display("FAIL stall_hold: stable=%0d words_buffered=%0d expected 1 and 2", stable, exp_q.size());
        end
        tests_run++;
        if (hold !== exp_q[0][63:0]) begin
          fail_cnt++;
          $display("FAIL stall_head: got %h expected %h", hold, exp_q[0][63:0]);
        end
        @(posedge clk);
        #1;
        M_AXIS_tready = 1'b1;
      end
    join
    wait_drain();
  endtask

  task automatic test_reset_mid();
    M_AXIS_tready = 1'b0;
    send_flit(16'h0102, 0);
    send_flit(16'h0304, 0);
    send_flit(16'h0506, 0);
    send_flit(16'h0708, 0);
    send_flit(16'h090A, 0);
    send_flit(16'h0B0C, 0);
    rst_n = 1'b0;
    #2;
    model_reset();
    tests_run++;
    if (M_AXIS_tvalid !== 1'b0 || err_cnt !== 16'h0 || link_ready !== 1'b0) begin
      fail_cnt++;
      $display("FAIL mid_reset: tvalid=%b err_cnt=%h ready=%b expected 0 0000 0",
               M_AXIS_tvalid, err_cnt, link_ready);
    end
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    M_AXIS_tready = 1'b1;
    send_flit(16'hAAAA, 0);
    send_flit(16'hBBBB, 0);
    send_flit(16'hCCCC, 0);
    send_flit(16'hDDDD, 0);
    tests_run++;
    if (M_AXIS_tdata !== 64'hAAAA_BBBB_CCCC_DDDD) begin
      fail_cnt++;
      $display("FAIL fresh_word: got %h expected aaaabbbbccccdddd", M_AXIS_tdata);
    end
    wait_drain();
  endtask

  task automatic test_saturation();
    link_data_in = 16'h0001;
    link_par     = 1'b0;
    link_valid   = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    tests_run++;
    if (err_cnt !== 16'hFFFE) begin
      fail_cnt++;
      $display("FAIL err_cnt_pre_sat: got %h expected fffe", err_cnt);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (err_cnt !== 16'hFFFF) begin
      fail_cnt++;
      $display("FAIL err_cnt_sat: got %h expected ffff", err_cnt);
    end
    repeat (4) @(posedge clk);
    #1;
    link_valid = 1'b0;
    tests_run++;
    if (err_cnt !== 16'hFFFF) begin
      fail_cnt++;
      $display("FAIL err_cnt_hold: got %h expected ffff", err_cnt);
    end
    wait_drain();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_end_marker();
    test_parity_err();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    tests_run++;
    if (exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL final_queue: %0d words left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
